// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard and forwarding unit for the in-order RISC-V pipeline. A small
// registered scoreboard follows every in-flight register write from EX
// (entry 1) down to WB (entry NUM_FWD_STAGES). From it the block derives
// the issue stall, the decode flush and one forwarding select per source.
//
// Optional build macro: HAZARD_SCOREBOARD_STATS_EN
//   defined   -> stall_cycles / flush_count are saturating event counters
//   undefined -> both ports are tied to zero and no counter flops exist
//
// Decode handshake: the instruction in decode issues into EX on a cycle
// where id_valid=1, stall_out=0 and ex_redirect=0. With stall_out=1 the
// front end must hold the same instruction. With ex_redirect=1 the
// instruction is killed (flush_id=1) and never issues.

module hazard_scoreboard #(
  parameter int NUM_FWD_STAGES = 3,
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_LAT       = 1,
  parameter int MULDIV_LAT     = 4,
  parameter int FWD_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_writes_rd,
  input  logic [1:0]            id_class,
  input  logic                  ex_redirect,
  output logic                  stall_out,
  output logic                  flush_id,
  output logic [FWD_W-1:0]      fwd_sel_rs1,
  output logic [FWD_W-1:0]      fwd_sel_rs2,
  output logic                  busy,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
);

  // Wait counter only has to hold LOAD_LAT; hold counter holds MULDIV_LAT-1.
  localparam int WAIT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;
  localparam int HOLD_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  localparam logic [1:0] CLS_ALU    = 2'd0;
  localparam logic [1:0] CLS_LOAD   = 2'd1;
  localparam logic [1:0] CLS_MULDIV = 2'd2;
  localparam logic [1:0] CLS_NONE   = 2'd3;

  // Scoreboard entries, index 1 = youngest (EX/MEM), NUM_FWD_STAGES = WB.
  logic [NUM_FWD_STAGES:1] ent_v;
  logic [REG_ADDR_W-1:0]   ent_rd   [1:NUM_FWD_STAGES];
  logic [WAIT_W-1:0]       ent_wait [1:NUM_FWD_STAGES];
  logic [HOLD_W-1:0]       hold_cnt;

  logic [NUM_FWD_STAGES:1] nxt_v;
  logic [REG_ADDR_W-1:0]   nxt_rd   [1:NUM_FWD_STAGES];
  logic [WAIT_W-1:0]       nxt_wait [1:NUM_FWD_STAGES];
  logic [HOLD_W-1:0]       nxt_hold;

  logic                    holding;
  logic [NUM_FWD_STAGES:1] match_ok;
  logic                    haz_rs1;
  logic                    haz_rs2;
  logic                    issue;

  // Saturating decrement applied to every entry that moves down the pipe.
  function automatic logic [WAIT_W-1:0] dec_sat(input logic [WAIT_W-1:0] w);
    return (w != '0) ? (w - WAIT_W'(1)) : '0;
  endfunction

  assign holding = (hold_cnt != '0);

  // Entries eligible for matching; entry 1 is the stalled mul/div during a hold.
  always_comb begin
    match_ok    = ent_v;
    match_ok[1] = ent_v[1] & ~holding;
  end

  // Source 1 lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    haz_rs1     = 1'b0;
    fwd_sel_rs1 = '0;
    if (id_uses_rs1 && (id_rs1 != '0)) begin
      for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
        if (match_ok[k] && (ent_rd[k] == id_rs1)) begin
          haz_rs1     = (ent_wait[k] != '0);
          fwd_sel_rs1 = (ent_wait[k] != '0) ? '0 : FWD_W'(k);
        end
      end
    end
  end

  // Source 2 lookup, same rule as source 1.
  always_comb begin
    haz_rs2     = 1'b0;
    fwd_sel_rs2 = '0;
    if (id_uses_rs2 && (id_rs2 != '0)) begin
      for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
        if (match_ok[k] && (ent_rd[k] == id_rs2)) begin
          haz_rs2     = (ent_wait[k] != '0);
          fwd_sel_rs2 = (ent_wait[k] != '0) ? '0 : FWD_W'(k);
        end
      end
    end
  end

  // Control outputs: the hold stalls regardless, a redirect masks data hazards.
  always_comb begin
    stall_out = holding | (id_valid & ~ex_redirect & (haz_rs1 | haz_rs2));
    flush_id  = ex_redirect;
    issue     = id_valid & ~stall_out & ~ex_redirect;
  end

  // Next scoreboard contents: shift down, then fill entry 1 by hold/issue/bubble.
  always_comb begin
    nxt_v    = ent_v;
    nxt_hold = hold_cnt;
    for (int k = 1; k <= NUM_FWD_STAGES; k++) begin
      nxt_rd[k]   = ent_rd[k];
      nxt_wait[k] = ent_wait[k];
    end

    for (int k = 2; k <= NUM_FWD_STAGES; k++) begin
      if (holding && (k == 2)) begin
        // The mul/div stays in EX, so MEM sees a bubble behind it.
        nxt_v[k]    = 1'b0;
        nxt_rd[k]   = '0;
        nxt_wait[k] = '0;
      end else begin
        nxt_v[k]    = ent_v[k-1];
        nxt_rd[k]   = ent_rd[k-1];
        nxt_wait[k] = dec_sat(ent_wait[k-1]);
      end
    end

    if (holding) begin
      // Entry 1 keeps its value while the mul/div occupies EX.
      nxt_hold = hold_cnt - HOLD_W'(1);
    end else if (issue) begin
      nxt_v[1]    = id_writes_rd & (id_class != CLS_NONE);
      nxt_rd[1]   = id_rd;
      nxt_wait[1] = (id_class == CLS_LOAD) ? WAIT_W'(LOAD_LAT) : '0;
      nxt_hold    = (id_class == CLS_MULDIV) ? HOLD_W'(MULDIV_LAT - 1) : '0;
    end else begin
      nxt_v[1]    = 1'b0;
      nxt_rd[1]   = '0;
      nxt_wait[1] = '0;
    end
  end

  // Scoreboard and hold counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_v    <= '0;
      hold_cnt <= '0;
      for (int k = 1; k <= NUM_FWD_STAGES; k++) begin
        ent_rd[k]   <= '0;
        ent_wait[k] <= '0;
      end
    end else begin
      ent_v    <= nxt_v;
      hold_cnt <= nxt_hold;
      for (int k = 1; k <= NUM_FWD_STAGES; k++) begin
        ent_rd[k]   <= nxt_rd[k];
        ent_wait[k] <= nxt_wait[k];
      end
    end
  end

  assign busy = |ent_v;

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating counts of stall cycles and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_out && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_id && (flush_cnt_q != '1))  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed test-plan sequences followed by random decode traffic. A model of
// the in-flight writes (slot array with the cycle at which each result becomes
// forwardable) produces the expected outputs each cycle; a monitor compares.

module tb_hazard_scoreboard;

  localparam int N          = 3;
  localparam int RW         = 5;
  localparam int LOAD_LAT   = 1;
  localparam int MULDIV_LAT = 4;
  localparam int FWD_W      = $clog2(N + 1);

  typedef struct packed {
    logic             stall;
    logic             flush;
    logic [FWD_W-1:0] sel1;
    logic [FWD_W-1:0] sel2;
    logic             busy;
    logic [31:0]      sc;
    logic [31:0]      fc;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          id_valid;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_uses_rs1, id_uses_rs2, id_writes_rd;
  logic [1:0]    id_class;
  logic          ex_redirect;
  logic          stall_out, flush_id, busy;
  logic [FWD_W-1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic [31:0]   stall_cycles, flush_count;

  hazard_scoreboard #(
    .NUM_FWD_STAGES(N),
    .REG_ADDR_W(RW),
    .LOAD_LAT(LOAD_LAT),
    .MULDIV_LAT(MULDIV_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_valid(id_valid),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd),
    .id_writes_rd(id_writes_rd),
    .id_class(id_class),
    .ex_redirect(ex_redirect),
    .stall_out(stall_out),
    .flush_id(flush_id),
    .fwd_sel_rs1(fwd_sel_rs1),
    .fwd_sel_rs2(fwd_sel_rs2),
    .busy(busy),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference model: slot k holds an in-flight write and the cycle from which
  // its value may be forwarded.
  bit            m_v     [1:N];
  logic [RW-1:0] m_rd    [1:N];
  int            m_ready [1:N];
  int            m_hold;
  longint        m_sc, m_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 1; k <= N; k++) begin
      m_v[k] = 0; m_rd[k] = '0; m_ready[k] = 0;
    end
    m_hold = 0; m_sc = 0; m_fc = 0;
  endtask

  function automatic void lookup(input logic [RW-1:0] r, input bit u,
                                 output bit haz, output logic [FWD_W-1:0] sel);
    haz = 0;
    sel = '0;
    if (!u || r == '0) return;
    for (int k = 1; k <= N; k++) begin
      if (k == 1 && m_hold > 0) continue;
      if (m_v[k] && m_rd[k] == r) begin
        if (cyc < m_ready[k]) haz = 1;
        else sel = FWD_W'(k);
        return;
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit v, input logic [RW-1:0] r1, input bit u1,
                       input logic [RW-1:0] r2, input bit u2, input logic [RW-1:0] rdi,
                       input bit wr, input logic [1:0] cls, input bit redir, input bit rs);
    exp_t e;
    bit h1, h2, hold_now, iss;
    logic [FWD_W-1:0] s1, s2;
    @(negedge clk);
    rst = rs; id_valid = v; id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2;
    id_uses_rs2 = u2; id_rd = rdi; id_writes_rd = wr; id_class = cls;
    ex_redirect = redir;

    hold_now = (m_hold > 0);
    lookup(r1, u1, h1, s1);
    lookup(r2, u2, h2, s2);
    e.stall = hold_now || (v && !redir && (h1 || h2));
    e.flush = redir;
    e.sel1  = s1;
    e.sel2  = s2;
    e.busy  = 0;
    for (int k = 1; k <= N; k++) if (m_v[k]) e.busy = 1;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    e.sc = m_sc[31:0];
    e.fc = m_fc[31:0];
`else
    e.sc = '0;
    e.fc = '0;
`endif
    exp_q.push_back(e);

    iss = v && !e.stall && !redir;
    if (rs) begin
      model_reset();
    end else begin
      if (e.stall && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (redir && m_fc < 64'hFFFF_FFFF) m_fc++;
      if (hold_now) begin
        for (int k = N; k >= 3; k--) begin
          m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ready[k] = m_ready[k-1];
        end
        if (N >= 2) m_v[2] = 0;
        m_hold--;
      end else begin
        for (int k = N; k >= 2; k--) begin
          m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ready[k] = m_ready[k-1];
        end
        m_v[1]     = iss && wr && (cls != 2'd3);
        m_rd[1]    = rdi;
        m_ready[1] = cyc + 1 + ((cls == 2'd1) ? LOAD_LAT : 0);
        if (iss && cls == 2'd2) m_hold = MULDIV_LAT - 1;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
  endtask

  // Hand-derived checks against literal values, sampled 1 time unit after drive.
  task automatic chk_now(input string tag, input bit s, input logic [FWD_W-1:0] e1,
                         input logic [FWD_W-1:0] e2);
    #1;
    chk({tag, "_stall"}, stall_out, s);
    if (!s) begin
      chk({tag, "_sel1"}, fwd_sel_rs1, e1);
      chk({tag, "_sel2"}, fwd_sel_rs2, e2);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_out", stall_out, e.stall);
        chk("flush_id", flush_id, e.flush);
        chk("busy", busy, e.busy);
        chk("stall_cycles", stall_cycles, e.sc);
        chk("flush_count", flush_count, e.fc);
        if (!e.stall && !e.flush) begin
          chk("fwd_sel_rs1", fwd_sel_rs1, e.sel1);
          chk("fwd_sel_rs2", fwd_sel_rs2, e.sel2);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    rst = 1; id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_writes_rd = 0; id_class = '0;
    ex_redirect = 0;
    repeat (2) @(negedge clk);
    model_reset();

    // reset state
    idle(1);
    chk_now("reset", 0, 0, 0);
    chk("reset_busy", busy, 0);
    chk("reset_flush", flush_id, 0);

    // ALU to ALU forwarding
    drive(1, 0, 0, 0, 0, 5, 1, 2'd0, 0, 0);
    drive(1, 5, 1, 6, 1, 7, 1, 2'd0, 0, 0);
    chk_now("alu_fwd", 0, 1, 0);
    idle(3);

    // load-use: one stall cycle, then forward from stage 2
    drive(1, 2, 1, 0, 0, 6, 1, 2'd1, 0, 0);
    drive(1, 3, 1, 6, 1, 10, 1, 2'd0, 0, 0);
    chk_now("loaduse_stall", 1, 0, 0);
    drive(1, 3, 1, 6, 1, 10, 1, 2'd0, 0, 0);
    chk_now("loaduse_fwd", 0, 0, 2);
    idle(3);

    // x0 never matches
    drive(1, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0);
    drive(1, 0, 1, 0, 1, 12, 1, 2'd0, 0, 0);
    chk_now("x0", 0, 0, 0);
    idle(3);

    // youngest of two writes to x8 wins
    drive(1, 0, 0, 0, 0, 8, 1, 2'd0, 0, 0);
    drive(1, 0, 0, 0, 0, 8, 1, 2'd0, 0, 0);
    drive(1, 8, 1, 0, 0, 13, 1, 2'd0, 0, 0);
    chk_now("youngest", 0, 1, 0);
    idle(3);

    // mul/div: three hold cycles, then forward from entry 1
    drive(1, 0, 0, 0, 0, 9, 1, 2'd2, 0, 0);
    repeat (3) begin
      drive(1, 9, 1, 0, 0, 14, 1, 2'd0, 0, 0);
      chk_now("mul_hold", 1, 0, 0);
    end
    drive(1, 9, 1, 0, 0, 14, 1, 2'd0, 0, 0);
    chk_now("mul_fwd", 0, 1, 0);
    idle(3);

    // older write followed by a non-writing mul: bubbles drain behind the hold
    drive(1, 0, 0, 0, 0, 20, 1, 2'd0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0);
    idle(5);

    // redirect over a load-use hazard, then entry 1 must be a bubble
    drive(1, 0, 0, 0, 0, 6, 1, 2'd1, 0, 0);
    drive(1, 0, 0, 6, 1, 6, 1, 2'd0, 1, 0);
    #1;
    chk("redirect_flush", flush_id, 1);
    chk("redirect_stall", stall_out, 0);
    drive(1, 0, 0, 6, 1, 15, 1, 2'd0, 0, 0);
    chk_now("redirect_bubble", 0, 0, 2);
    idle(3);

    // redirect during a hold keeps the hold running
    drive(1, 0, 0, 0, 0, 9, 1, 2'd2, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
    #1;
    chk("hold_redirect_flush", flush_id, 1);
    chk("hold_redirect_stall", stall_out, 1);
    idle(4);

    // reset in the second hold cycle
    drive(1, 0, 0, 0, 0, 9, 1, 2'd2, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
    idle(1);
    #1;
    chk("rst_hold_busy", busy, 0);
    chk("rst_hold_stall", stall_out, 0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    chk("rst_hold_stall_cycles", stall_cycles, 0);
`endif

    // random traffic
    repeat (800) begin
      drive($urandom_range(0, 3) != 0,
            RW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            RW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            RW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 99) == 0);
    end
    idle(2);

    @(negedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding unit for the in-order RISC-V pipeline. It tracks in-flight register writes from EX through WB in a registered scoreboard and generates issue stalls, front-end flushes and per-source forwarding selects. Compared with the earlier combinational control block, it adds configurable forwarding depth, configurable load latency and multi-cycle mul/div occupancy with a hold counter. It sits beside the decode stage and its outputs drive the ID/EX operand muxes and the fetch/decode stall logic.

Parameters:
NUM_FWD_STAGES, 3, number of tracked stages after ID (1 = EX/MEM ... N = WB).
REG_ADDR_W, 5, register index width.
LOAD_LAT, 1, cycles a load result stays non-forwardable after leaving EX (valid range 0..NUM_FWD_STAGES-1).
MULDIV_LAT, 4, total EX cycles occupied by a mul/div (minimum 1).
FWD_W, $clog2(NUM_FWD_STAGES+1), width of the forward selects (derived).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
id_valid  in  1  decode holds a valid instruction.
id_rs1, id_rs2  in  REG_ADDR_W  decode source indices.
id_uses_rs1, id_uses_rs2  in  1  the corresponding source is read.
id_rd  in  REG_ADDR_W  decode destination index.
id_writes_rd  in  1  instruction writes rd.
id_class  in  2  0 = alu/lui/auipc/jal/jalr, 1 = load, 2 = muldiv, 3 = no result.
ex_redirect  in  1  taken branch or jump resolved in EX.
stall_out  out  1  hold PC and IF/ID; insert a bubble into EX.
flush_id  out  1  kill the instruction in decode.
fwd_sel_rs1, fwd_sel_rs2  out  FWD_W  0 = register file, k = stage k result.
busy  out  1  any scoreboard entry is valid.

Behaviour:
- State: entries 1..N, each holding {v, rd, wait} (wait is a down-counter, 0 = forwardable), plus hold_cnt for mul/div.
- An entry is a match for a source when v=1, rd = rs, and rs != 0. Register x0 never matches, never stalls, and always selects 0.
- Per used source, combinationally: take the youngest matching entry (lowest k). If its wait is greater than 0, the source raises a hazard; otherwise fwd_sel = k. With no match, fwd_sel = 0. An unused source always gives fwd_sel = 0 and no hazard.
- stall_out = hold_cnt>0 OR (id_valid AND not ex_redirect AND any hazard).
- flush_id = ex_redirect. Redirect takes priority over a data-hazard stall.
- Each cycle, entries k=2..N load entry k-1, and entry N retires. Every advancing entry decrements wait, saturating at 0.
- Issue (id_valid, no stall, no redirect): entry 1 gets v = id_writes_rd AND id_class != 3, and rd = id_rd. wait = LOAD_LAT for a load, 0 otherwise. For muldiv, hold_cnt is set to MULDIV_LAT-1.
- No issue: entry 1 becomes a bubble (v=0).
- Mul/div hold (hold_cnt > 0): entry 1 holds its value, entry 2 receives a bubble, entries 3..N advance, and hold_cnt decrements. Forwarding from entry 1 is suppressed during the hold, which the hold stall covers.
- ex_redirect during a hold: flush_id=1 and the hold continues unchanged.
- Priority: rst > mul/div hold > redirect > data-hazard stall > issue.
- Reset: all v=0, wait=0, hold_cnt=0. Outputs after reset: stall_out=0 (while id_valid=0), flush_id=ex_redirect, fwd_sel=0, busy=0. A reset asserted mid-hold clears hold_cnt on the next edge.
- busy is the OR of all v bits and is registered-derived.

Optional Feature:
Macro HAZARD_SCOREBOARD_STATS_EN.
- Defined: adds outputs stall_cycles [31:0] and flush_count [31:0]. stall_cycles counts cycles with stall_out=1; flush_count counts cycles with flush_id=1. Both saturate at all-ones and clear on rst.
- Undefined: the ports are still present, tied to 0, and no counter flops are inferred.

Test Plan:
- ALU-to-ALU: cycle 0 issue add x5 (class 0). Cycle 1 decode add x7,x5,x6 -> fwd_sel_rs1=1, fwd_sel_rs2=0, stall_out=0.
- Load-use with LOAD_LAT=1: lw x6 issued, next decode uses rs2=x6 -> stall_out=1 for exactly 1 cycle, then fwd_sel_rs2=2 with no stall.
- x0 and youngest-wins:
  - Write x0, then read x0 -> fwd_sel=0, no stall.
  - Two writes to x8 in consecutive cycles, then read x8 -> fwd_sel=1.
- Mul/div with MULDIV_LAT=4: mul x9 issued -> stall_out=1 for 3 cycles, entry 2 receives bubbles, and a dependent instruction then sees fwd_sel=1.
- Redirect: ex_redirect=1 while decode has a hazard -> flush_id=1, stall_out=0, and entry 1 is a bubble next cycle.
- Reset mid-hold: rst in the second hold cycle -> busy=0, stall_out=0, and hold_cnt=0 on the next edge. With HAZARD_SCOREBOARD_STATS_EN, stall_cycles=0 after reset.
